// File: rtl/aes_axil_block_bridge.sv
// AXI4-Lite register bridge for an AES block core: software loads DIN/KEY, starts the core
// through CTRL, and reads the result from DOUT. STATUS and irq report completion.
module aes_axil_block_bridge #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned BLOCK_WIDTH        = 128
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            aes_blk_valid,
  input  logic                            aes_blk_ready,
  output logic [BLOCK_WIDTH-1:0]          aes_din,
  output logic [BLOCK_WIDTH-1:0]          aes_key,
  output logic                            aes_decrypt,
  input  logic                            aes_res_valid,
  output logic                            aes_res_ready,
  input  logic [BLOCK_WIDTH-1:0]          aes_dout,
  output logic                            irq
);

  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned BW     = BLOCK_WIDTH;
  localparam int unsigned SW     = DW / 8;
  localparam int unsigned WW     = AW - 2;
  localparam int unsigned N      = BW / DW;
  localparam int unsigned CTRL_W = 2 * N;
  localparam int unsigned STAT_W = 2 * N + 1;
  localparam int unsigned DOUT_W = 2 * N + 2;
  localparam int unsigned NWORDS = 3 * N + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic                   aw_full_q, w_full_q, bvalid_q;
  logic [WW-1:0]          aw_word_q;
  logic [DW-1:0]          wdata_q;
  logic [SW-1:0]          wstrb_q;
  logic [1:0]             bresp_q;
  logic [N-1:0][DW-1:0]   din_q, key_q, dout_q;
  logic                   decrypt_q, ie_q, start_q;
  logic                   busy_q, done_q, overrun_q, irq_q;
  logic                   rvalid_q, rd_stat_q;
  logic [DW-1:0]          rdata_q, rd_data;
  logic [1:0]             rresp_q;
  logic                   blk_valid_q, res_ready_q, aes_dec_q;
  logic [BW-1:0]          aes_din_q, aes_key_q;
  logic                   snap, finish, ovr_set;
  logic                   do_write, b_hs, ar_hs, r_hs, ctrl_wr, stat_clr;
  logic                   ie_d, done_d, overrun_d;
  logic [31:0]            wr_idx, ar_idx;
  logic                   unused_addr_lsbs;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int unsigned b = 0; b < SW; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  assign S_AXI_AWREADY = !ARESET && !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = !ARESET && !w_full_q && !bvalid_q;
  assign S_AXI_ARREADY = !ARESET && !rvalid_q;

  assign do_write = aw_full_q && w_full_q && !bvalid_q;
  assign b_hs     = bvalid_q && S_AXI_BREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs     = rvalid_q && S_AXI_RREADY;
  assign wr_idx   = 32'(aw_word_q);
  assign ar_idx   = 32'(S_AXI_ARADDR[AW-1:2]);
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign ctrl_wr   = do_write && (wr_idx == CTRL_W) && wstrb_q[0];
  assign ie_d      = ctrl_wr ? wdata_q[2] : ie_q;
  assign stat_clr  = r_hs && rd_stat_q;
  // A completion in the same cycle as a STATUS-read clear keeps the flag set
  assign done_d    = finish || (done_q && !stat_clr);
  assign overrun_d = ovr_set || (overrun_q && !stat_clr);

  // Write channel: one AW/W pair buffered, response held until BREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_word_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full_q <= 1'b1;
        aw_word_q <= S_AXI_AWADDR[AW-1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (do_write) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_idx < NWORDS) ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
    end
  end

  // Software-writable registers; START is a one-cycle pulse
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      din_q     <= '0;
      key_q     <= '0;
      decrypt_q <= 1'b0;
      ie_q      <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ie_q    <= ie_d;
      if (do_write) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (wr_idx == i)     din_q[i] <= merge_bytes(din_q[i], wdata_q, wstrb_q);
          if (wr_idx == N + i) key_q[i] <= merge_bytes(key_q[i], wdata_q, wstrb_q);
        end
      end
      if (ctrl_wr) begin
        start_q   <= wdata_q[0];
        decrypt_q <= wdata_q[1];
      end
    end
  end

  // Core handshake FSM
  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    finish  = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_SEND;
          snap    = 1'b1;
        end
      end
      S_SEND: begin
        ovr_set = start_q;
        if (blk_valid_q && aes_blk_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        ovr_set = start_q;
        if (res_ready_q && aes_res_valid) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      blk_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
      aes_din_q   <= '0;
      aes_key_q   <= '0;
      aes_dec_q   <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      blk_valid_q <= (state_d == S_SEND);
      res_ready_q <= (state_d == S_WAIT);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      irq_q       <= done_d && ie_d;
      if (snap) begin
        aes_din_q <= din_q;
        aes_key_q <= key_q;
        aes_dec_q <= decrypt_q;
      end
      if (finish) dout_q <= aes_dout;
    end
  end

  // Read data mux; unmapped words return zero
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ar_idx == i)          rd_data = din_q[i];
      if (ar_idx == N + i)      rd_data = key_q[i];
      if (ar_idx == DOUT_W + i) rd_data = dout_q[i];
    end
    if (ar_idx == CTRL_W) rd_data = DW'({ie_q, decrypt_q, 1'b0});
    if (ar_idx == STAT_W) rd_data = DW'({overrun_q, done_q, busy_q});
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_stat_q <= 1'b0;
    end else if (ar_hs) begin
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_data;
      rresp_q   <= (ar_idx < NWORDS) ? RESP_OKAY : RESP_SLVERR;
      rd_stat_q <= (ar_idx == STAT_W);
    end else if (r_hs) begin
      rvalid_q  <= 1'b0;
      rd_stat_q <= 1'b0;
    end
  end

  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign aes_blk_valid = blk_valid_q;
  assign aes_res_ready = res_ready_q;
  assign aes_din       = aes_din_q;
  assign aes_key       = aes_key_q;
  assign aes_decrypt   = aes_dec_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_aes_axil_block_bridge.sv
// Scoreboard bench for aes_axil_block_bridge: stimulus queues expected B/R/core responses,
// a negedge monitor pops and compares them on every handshake.
module tb_aes_axil_block_bridge;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 128;
  localparam int RDY_DLY = 3;
  localparam int RES_DLY = 10;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic aes_blk_valid, aes_blk_ready, aes_decrypt, aes_res_valid, aes_res_ready, irq;
  logic [BW-1:0] aes_din, aes_key, aes_dout;

  int checks = 0;
  int errors = 0;
  logic [1:0]   bq[$];
  logic [33:0]  rq[$];
  logic [256:0] cq[$];
  logic [33:0]  re;
  logic [256:0] ce;
  logic core_stall = 1'b0;
  logic res_stall  = 1'b0;

  localparam logic [BW-1:0] RESULT = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [BW-1:0] KEY    = 128'h000102030405060708090A0B0C0D0E0F;

  always #5 ACLK = ~ACLK;

  aes_axil_block_bridge dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .aes_blk_valid(aes_blk_valid), .aes_blk_ready(aes_blk_ready), .aes_din(aes_din),
    .aes_key(aes_key), .aes_decrypt(aes_decrypt), .aes_res_valid(aes_res_valid),
    .aes_res_ready(aes_res_ready), .aes_dout(aes_dout), .irq(irq)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er);
    bit aw_ok, w_ok, b_ok, aw_hs, w_hs;
    bq.push_back(er);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; b_ok = 1'b0;
    for (int t = 0; t < 50 && !(aw_ok && w_ok); t++) begin
      @(negedge ACLK);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      cyc(1);
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_ok = 1'b1; end
      if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_ok  = 1'b1; end
    end
    if (!(aw_ok && w_ok)) timeout("write_addr_data");
    for (int t = 0; t < 50 && !b_ok; t++) begin
      @(negedge ACLK);
      b_ok = S_AXI_BVALID && S_AXI_BREADY;
      cyc(1);
    end
    if (!b_ok) timeout("write_resp");
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit ar_ok, r_ok;
    rq.push_back({er, ed});
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    ar_ok = 1'b0; r_ok = 1'b0;
    for (int t = 0; t < 50 && !ar_ok; t++) begin
      @(negedge ACLK);
      ar_ok = S_AXI_ARREADY;
      cyc(1);
    end
    S_AXI_ARVALID = 1'b0;
    if (!ar_ok) timeout("read_addr");
    for (int t = 0; t < 50 && !r_ok; t++) begin
      @(negedge ACLK);
      r_ok = S_AXI_RVALID && S_AXI_RREADY;
      cyc(1);
    end
    if (!r_ok) timeout("read_data");
  endtask

  // Scoreboard monitor
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) timeout("unexpected_bresp");
        else check("bresp", 128'(S_AXI_BRESP), 128'(bq.pop_front()));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) timeout("unexpected_rdata");
        else begin
          re = rq.pop_front();
          check("rdata", 128'(S_AXI_RDATA), 128'(re[31:0]));
          check("rresp", 128'(S_AXI_RRESP), 128'(re[33:32]));
        end
      end
      if (aes_blk_valid && aes_blk_ready) begin
        if (cq.size() == 0) timeout("unexpected_core_block");
        else begin
          ce = cq.pop_front();
          check("core_din", aes_din, ce[127:0]);
          check("core_key", aes_key, ce[255:128]);
          check("core_decrypt", 128'(aes_decrypt), 128'(ce[256]));
        end
      end
    end
  end

  // Core model: accepts a block RDY_DLY cycles after valid, answers RES_DLY cycles later
  initial begin : core_model
    int cm;
    int cnt;
    aes_blk_ready = 1'b0; aes_res_valid = 1'b0; aes_dout = '0;
    cm = 0; cnt = 0;
    forever begin
      @(posedge ACLK); #1;
      case (cm)
        0: if (aes_blk_valid && !core_stall) begin cnt = 0; cm = 1; end
        1: if (cnt >= RDY_DLY - 1) begin aes_blk_ready = 1'b1; cm = 2; end else cnt++;
        2: begin aes_blk_ready = 1'b0; cnt = 0; cm = 3; end
        3: if (cnt >= RES_DLY - 1 && !res_stall) begin
             aes_res_valid = 1'b1; aes_dout = RESULT; cm = 4;
           end else cnt++;
        default: begin aes_res_valid = 1'b0; aes_dout = '0; cm = 0; end
      endcase
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, n2;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_outputs", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
          S_AXI_RVALID, aes_blk_valid, aes_res_ready, irq, aes_decrypt}), 128'(0));
    check("reset_din", aes_din, '0);
    cyc(1);
    ARESET = 1'b0;
    cyc(1);
    check("awready_after_reset", 128'(S_AXI_AWREADY), 128'(1));

    // Test 1: DIN write/readback, no snapshot
    axi_write(6'h00, 32'h00112233, 4'hF, 2'b00);
    axi_write(6'h04, 32'h44556677, 4'hF, 2'b00);
    axi_write(6'h08, 32'h8899AABB, 4'hF, 2'b00);
    axi_write(6'h0C, 32'hCCDDEEFF, 4'hF, 2'b00);
    axi_read(6'h00, 32'h00112233, 2'b00);
    axi_read(6'h04, 32'h44556677, 2'b00);
    axi_read(6'h08, 32'h8899AABB, 2'b00);
    axi_read(6'h0C, 32'hCCDDEEFF, 2'b00);
    check("aes_din_idle", aes_din, '0);

    // Test 2: byte strobes
    axi_write(6'h00, 32'hFFFFFFFF, 4'hF, 2'b00);
    axi_write(6'h00, 32'h12345678, 4'b0101, 2'b00);
    axi_read(6'h00, 32'hFF34FF78, 2'b00);

    // Test 3: full encrypt with interrupt
    axi_write(6'h00, 32'h00112233, 4'hF, 2'b00);
    axi_write(6'h10, 32'h0C0D0E0F, 4'hF, 2'b00);
    axi_write(6'h14, 32'h08090A0B, 4'hF, 2'b00);
    axi_write(6'h18, 32'h04050607, 4'hF, 2'b00);
    axi_write(6'h1C, 32'h00010203, 4'hF, 2'b00);
    axi_read(6'h1C, 32'h00010203, 2'b00);
    cq.push_back({1'b0, KEY, 128'hCCDDEEFF_8899AABB_44556677_00112233});
    axi_write(6'h20, 32'h5, 4'hF, 2'b00);
    axi_read(6'h24, 32'h1, 2'b00);
    n = 0;
    while (n < 100 && !irq) begin cyc(1); n++; end
    check("irq_raised", 128'(irq), 128'(1));
    axi_read(6'h24, 32'h2, 2'b00);
    axi_read(6'h28, 32'h70B4C55A, 2'b00);
    axi_read(6'h2C, 32'hD8CDB780, 2'b00);
    axi_read(6'h30, 32'h6A7B0430, 2'b00);
    axi_read(6'h34, 32'h69C4E0D8, 2'b00);
    axi_read(6'h24, 32'h0, 2'b00);
    axi_read(6'h20, 32'h4, 2'b00);
    check("irq_cleared", 128'(irq), 128'(0));

    // Test 4: START while busy, DIN write while busy
    core_stall = 1'b1;
    cq.push_back({1'b1, KEY, 128'hCCDDEEFF_8899AABB_44556677_00112233});
    axi_write(6'h20, 32'h3, 4'hF, 2'b00);
    axi_write(6'h20, 32'h1, 4'hF, 2'b00);
    axi_write(6'h08, 32'h13579BDF, 4'hF, 2'b00);
    axi_read(6'h24, 32'h5, 2'b00);
    core_stall = 1'b0;
    cyc(40);
    axi_read(6'h24, 32'h2, 2'b00);
    check("irq_masked", 128'(irq), 128'(0));

    // Test 5: unmapped and read-only words
    axi_write(6'h3C, 32'hDEADBEEF, 4'hF, 2'b10);
    axi_read(6'h3C, 32'h0, 2'b10);
    axi_write(6'h24, 32'h7, 4'hF, 2'b00);
    axi_write(6'h28, 32'h0, 4'hF, 2'b00);
    axi_read(6'h24, 32'h0, 2'b00);
    axi_read(6'h28, 32'h70B4C55A, 2'b00);
    axi_read(6'h00, 32'h00112233, 2'b00);

    // Test 6: AW ahead of W, BREADY stalled
    S_AXI_BREADY = 1'b0;
    bq.push_back(2'b00);
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (n < 20 && !S_AXI_AWREADY) begin cyc(1); n++; end
    cyc(1);
    S_AXI_AWVALID = 1'b0;
    n = 0;
    repeat (5) begin if (S_AXI_AWREADY) n++; cyc(1); end
    check("awready_blocked", 128'(n), 128'(0));
    S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    n = 0;
    while (n < 20 && !S_AXI_WREADY) begin cyc(1); n++; end
    cyc(1);
    S_AXI_WVALID = 1'b0;
    n = 0;
    while (n < 20 && !S_AXI_BVALID) begin cyc(1); n++; end
    n = 0; n2 = 0;
    repeat (4) begin
      if (S_AXI_BVALID) n++;
      if (S_AXI_AWREADY) n2++;
      cyc(1);
    end
    check("bvalid_held", 128'(n), 128'(4));
    check("awready_while_bvalid", 128'(n2), 128'(0));
    S_AXI_BREADY = 1'b1;
    cyc(1);
    check("slots_cleared", 128'({S_AXI_BVALID, S_AXI_AWREADY}), 128'(2'b01));
    axi_read(6'h04, 32'hA5A5A5A5, 2'b00);

    // Reset while waiting for the result, then a late result
    res_stall = 1'b1;
    cq.push_back({1'b0, KEY, 128'hCCDDEEFF_13579BDF_A5A5A5A5_00112233});
    axi_write(6'h20, 32'h1, 4'hF, 2'b00);
    n = 0;
    while (n < 50 && !aes_res_ready) begin cyc(1); n++; end
    check("reached_wait", 128'(aes_res_ready), 128'(1));
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("reset_wait_ctl", 128'({aes_blk_valid, aes_res_ready, aes_decrypt, irq,
          S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY}), 128'(0));
    check("reset_wait_din", aes_din, '0);
    check("reset_wait_key", aes_key, '0);
    cyc(1);
    ARESET = 1'b0;
    res_stall = 1'b0;
    cyc(4);
    axi_read(6'h24, 32'h0, 2'b00);
    axi_read(6'h28, 32'h0, 2'b00);
    axi_read(6'h04, 32'h0, 2'b00);
    axi_read(6'h20, 32'h0, 2'b00);

    cyc(2);
    check("queues_drained", 128'(bq.size() + rq.size() + cq.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
